// File: rtl/ac_motor_sine_3ph_pkg.sv
// Shared widths, phase offsets and quarter-wave sine contents for the
// three-phase sine reference generator.
package ac_motor_sine_3ph_pkg;

  localparam int PHASE_W   = 20;
  localparam int ADDR_W    = 10;
  localparam int SINE_W    = 12;
  localparam int AMP_W     = 12;
  localparam int FREQ_W    = 12;
  localparam int OUT_W     = SINE_W + AMP_W;
  localparam int QTR_AW    = ADDR_W - 2;
  localparam int QTR_DEPTH = 1 << QTR_AW;
  localparam int MAG_W     = SINE_W - 1;
  localparam int NUM_PH    = 3;

  localparam logic [ADDR_W-1:0] OFFS_120  = ADDR_W'(341);
  localparam logic [ADDR_W-1:0] OFFS_240  = ADDR_W'(683);
  localparam logic [MAG_W-1:0]  SINE_PEAK = MAG_W'(2047);

  typedef enum logic [1:0] {
    DIR_HOLD,
    DIR_CW,
    DIR_CCW,
    DIR_LOCK
  } dir_e;

  // Fixed-point Taylor series used only at elaboration to fill the table:
  // entry k = round(2047 * sin(k * pi / 512)), k in 0..255.
  localparam int     FRAC_W   = 30;
  localparam longint PI_Q     = 64'sd3373259426;
  localparam int     TAYLOR_N = 8;

  function automatic logic [MAG_W-1:0] quarter_sine(input int k);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (longint'(k) * PI_Q) >>> (ADDR_W - 1);
    x2   = (x * x) >>> FRAC_W;
    term = x;
    acc  = x;
    for (int n = 1; n <= TAYLOR_N; n++) begin
      term = -((term * x2) >>> FRAC_W) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return MAG_W'((acc * longint'(SINE_PEAK) + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W);
  endfunction

endpackage

// File: rtl/ac_motor_sine_3ph_sine_quarter_lut.sv
// Full-period sine lookup built from a 256-entry quarter-wave table with
// quadrant mirroring/negation; the sample is registered.
module ac_motor_sine_3ph_sine_quarter_lut
  import ac_motor_sine_3ph_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [SINE_W-1:0] sample_o
);

  // NOTE: the table is a constant ROM, so it has no reset; only the sample
  // register that follows it is cleared.
  logic [MAG_W-1:0] rom [QTR_DEPTH];

  for (genvar k = 0; k < QTR_DEPTH; k++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = quarter_sine(k);
    assign rom[k] = ENTRY;
  end

  logic [1:0]          quadrant;
  logic [QTR_AW-1:0]   offset;
  logic [QTR_AW:0]     mirror_idx;
  logic [MAG_W-1:0]    magnitude;
  logic [SINE_W-1:0]   sample_d;
  logic [SINE_W-1:0]   sample_q;

  assign quadrant = addr_i[ADDR_W-1 -: 2];
  assign offset   = addr_i[QTR_AW-1:0];

  // NOTE: every signal driven here gets a value on every path before any
  // condition, so no latch can be inferred.
  always_comb begin
    mirror_idx = {1'b0, offset};
    if (quadrant[0]) begin
      mirror_idx = (QTR_AW + 1)'(QTR_DEPTH) - {1'b0, offset};
    end
    // Index 256 (the crest of quadrants 1 and 3) lies just past the table.
    if (mirror_idx[QTR_AW]) begin
      magnitude = SINE_PEAK;
    end else begin
      magnitude = rom[mirror_idx[QTR_AW-1:0]];
    end
    sample_d = {1'b0, magnitude};
    if (quadrant[1]) begin
      sample_d = -{1'b0, magnitude};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs as they were before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/ac_motor_sine_3ph.sv
// Three-phase sine reference generator: phase accumulator with direction and
// lock control, three 120-degree spaced lookups, signed amplitude scaling.
module ac_motor_sine_3ph
  import ac_motor_sine_3ph_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FREQ_W-1:0] frequency,
  input  logic [AMP_W-1:0]  amplitude,
  input  logic              cw,
  input  logic              ccw,
  input  logic              lock,
  output logic [OUT_W-1:0]  sine1,
  output logic [OUT_W-1:0]  sine2,
  output logic [OUT_W-1:0]  sine3
);

  dir_e                dir;
  logic [PHASE_W-1:0]  phase_d;
  logic [PHASE_W-1:0]  phase_q;
  logic [ADDR_W-1:0]   addr [NUM_PH];
  logic [SINE_W-1:0]   sample [NUM_PH];
  logic signed [OUT_W-1:0] prod_d [NUM_PH];
  logic signed [OUT_W-1:0] prod_q [NUM_PH];

  always_comb begin
    dir = DIR_HOLD;
    if (lock) begin
      dir = DIR_LOCK;
    end else if (cw && !ccw) begin
      dir = DIR_CW;
    end else if (!cw && ccw) begin
      dir = DIR_CCW;
    end
  end

  always_comb begin
    phase_d = phase_q;
    unique case (dir)
      DIR_LOCK: phase_d = '0;
      DIR_CW:   phase_d = phase_q + PHASE_W'(frequency);
      DIR_CCW:  phase_d = phase_q - PHASE_W'(frequency);
      DIR_HOLD: phase_d = phase_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign addr[0] = phase_q[PHASE_W-1 -: ADDR_W];
  assign addr[1] = addr[0] + OFFS_120;
  assign addr[2] = addr[0] + OFFS_240;

  for (genvar k = 0; k < NUM_PH; k++) begin : g_phase
    ac_motor_sine_3ph_sine_quarter_lut u_lut (
      .clk      (clk),
      .reset_n  (reset_n),
      .addr_i   (addr[k]),
      .sample_o (sample[k])
    );
  end

  // Operands are sign-extended to the full product width first; the
  // worst case -2047 * -2048 still fits, so nothing is truncated.
  always_comb begin
    for (int k = 0; k < NUM_PH; k++) begin
      prod_d[k] = OUT_W'($signed(sample[k])) * OUT_W'($signed(amplitude));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_PH; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PH; k++) begin
        prod_q[k] <= prod_d[k];
      end
    end
  end

  assign sine1 = prod_q[0];
  assign sine2 = prod_q[1];
  assign sine3 = prod_q[2];

endmodule

// File: tb/tb_ac_motor_sine_3ph.sv
// Scoreboard bench for ac_motor_sine_3ph: a behavioural model built on $sin
// predicts each output triple before the clock edge that produces it.
module tb_ac_motor_sine_3ph;

  logic        clk;
  logic        reset_n;
  logic [11:0] frequency;
  logic [11:0] amplitude;
  logic        cw;
  logic        ccw;
  logic        lock;
  logic [23:0] sine1;
  logic [23:0] sine2;
  logic [23:0] sine3;

  ac_motor_sine_3ph dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frequency (frequency),
    .amplitude (amplitude),
    .cw        (cw),
    .ccw       (ccw),
    .lock      (lock),
    .sine1     (sine1),
    .sine2     (sine2),
    .sine3     (sine3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s1;
    int s2;
    int s3;
  } exp_t;

  exp_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned m_phase;
  int          m_samp [3];
  int          offs [3] = '{0, 341, 683};

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int s24(input logic [23:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s_ref(input int a);
    real r;
    r = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 1024.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  task automatic model_reset();
    m_phase = 0;
    for (int k = 0; k < 3; k++) m_samp[k] = 0;
    sb.delete();
  endtask

  // Called at a falling edge with inputs already driven: predict, clock, compare.
  task automatic step();
    exp_t        e;
    exp_t        got_e;
    int          samp_n [3];
    int unsigned ph_n;
    int          amp;
    amp  = int'($signed(amplitude));
    e.s1 = m_samp[0] * amp;
    e.s2 = m_samp[1] * amp;
    e.s3 = m_samp[2] * amp;
    for (int k = 0; k < 3; k++) begin
      samp_n[k] = s_ref((int'(m_phase >> 10) + offs[k]) % 1024);
    end
    if (lock)              ph_n = 0;
    else if (cw && !ccw)   ph_n = (m_phase + frequency) & 32'hFFFFF;
    else if (!cw && ccw)   ph_n = (m_phase - frequency) & 32'hFFFFF;
    else                   ph_n = m_phase;
    sb.push_back(e);
    @(posedge clk);
    m_phase = ph_n;
    m_samp  = samp_n;
    @(negedge clk);
    got_e = sb.pop_front();
    check("sb_sine1", s24(sine1), got_e.s1);
    check("sb_sine2", s24(sine2), got_e.s2);
    check("sb_sine3", s24(sine3), got_e.s3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    frequency = '0;
    amplitude = '0;
    cw        = 1'b0;
    ccw       = 1'b0;
    lock      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_sine1", s24(sine1), 0);
    check("rst_sine2", s24(sine2), 0);
    check("rst_sine3", s24(sine3), 0);
    reset_n = 1'b1;

    // Static angle at phase 0
    amplitude = 12'd1000;
    cw        = 1'b1;
    repeat (2) step();
    check("static_sine1", s24(sine1), 0);
    check("static_sine2", s24(sine2), 1775000);
    check("static_sine3", s24(sine3), -1775000);

    // Clockwise, one LUT step per clock, through a full wrap
    frequency = 12'd1024;
    amplitude = 12'd1;
    for (int i = 1; i <= 1030; i++) begin
      step();
      if (i == 258)  check("cw_peak", s24(sine1), 2047);
      if (i == 1026) check("cw_wrap", s24(sine1), 0);
    end

    // Counter-clockwise from a locked zero angle
    cw   = 1'b0;
    lock = 1'b1;
    step();
    lock = 1'b0;
    ccw  = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (i == 258) check("ccw_trough", s24(sine1), -2047);
    end

    // Lock then hold with cw=ccw=1
    ccw       = 1'b0;
    cw        = 1'b1;
    frequency = 12'd777;
    amplitude = 12'd300;
    repeat (20) step();
    lock = 1'b1;
    step();
    lock = 1'b0;
    ccw  = 1'b1;
    repeat (2) step();
    check("lock_sine1", s24(sine1), 0);
    check("lock_sine2", s24(sine2), 532500);
    repeat (5) step();
    check("hold_sine2", s24(sine2), 532500);

    // Lock release resumes from phase 0
    ccw  = 1'b0;
    lock = 1'b1;
    step();
    lock      = 1'b0;
    frequency = 12'd1024;
    amplitude = 12'd1;
    repeat (3) step();
    check("resume_sine1", s24(sine1), s_ref(1));

    // Amplitude extremes at a1 = 256
    lock = 1'b1;
    step();
    lock      = 1'b0;
    frequency = 12'd2048;
    repeat (128) step();
    frequency = 12'd0;
    amplitude = 12'h800;
    repeat (2) step();
    check("amp_min", s24(sine1), -4192256);
    amplitude = 12'h7FF;
    step();
    check("amp_max", s24(sine1), 4190209);
    amplitude = 12'd0;
    step();
    check("amp_zero1", s24(sine1), 0);
    check("amp_zero2", s24(sine2), 0);
    check("amp_zero3", s24(sine3), 0);

    // Random direction, lock, frequency and amplitude
    for (int i = 0; i < 300; i++) begin
      lock      = ($urandom_range(0, 15) == 0);
      cw        = 1'($urandom);
      ccw       = 1'($urandom);
      frequency = 12'($urandom);
      amplitude = 12'($urandom);
      step();
    end

    // Asynchronous reset mid-rotation
    lock      = 1'b0;
    cw        = 1'b1;
    ccw       = 1'b0;
    frequency = 12'd500;
    amplitude = 12'd1500;
    repeat (10) step();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_sine1", s24(sine1), 0);
    check("async_rst_sine2", s24(sine2), 0);
    check("async_rst_sine3", s24(sine3), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
